// File: rtl/piso_tx_pkg.sv
// rtl/piso_tx_pkg.sv - state encoding shared by the piso_tx transmitter
package piso_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam state_t STATE_RESET = IDLE;

endpackage

// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - N-bit load/shift register feeding the serial output
module piso_shift_reg #(
  parameter int N         = 5,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [N-1:0] din,
  output logic         bit_out
);

  logic [N-1:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= LSB_FIRST ? (q >> 1) : (q << 1);
    end
  end

  // The bit on offer always sits at the end the register shifts towards.
  assign bit_out = LSB_FIRST ? q[0] : q[N-1];

endmodule

// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in serial-out transmitter with valid/ready on both sides
// Optional even-parity bit after the data bits when PISO_TX_PARITY_EN is defined.
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int   N         = 5,
  parameter logic IDLE_VAL  = 1'b1,
  parameter bit   LSB_FIRST = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] data_i,
  input  logic         valid_i,
  output logic         ready_o,
  output logic         sdata_o,
  output logic         svalid_o,
  input  logic         sready_i,
  output logic         busy_o,
  output logic         done_o
);

  localparam int            CW   = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          done, done_next;
  logic          load, shift, bit_out;

  piso_shift_reg #(
    .N         (N),
    .LSB_FIRST (LSB_FIRST)
  ) u_shift_reg (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .load    (load),
    .shift   (shift),
    .din     (data_i),
    .bit_out (bit_out)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= STATE_RESET;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      done  <= done_next;
    end
  end

`ifdef PISO_TX_PARITY_EN
  logic par;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      par <= 1'b0;
    end else if (load) begin
      par <= ^data_i;
    end
  end
`endif

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_next  = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    sdata_o    = IDLE_VAL;
    case (state)
      IDLE: begin
        if (valid_i) begin
          load       = 1'b1;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        sdata_o = bit_out;
        if (sready_i) begin
          shift    = 1'b1;
          cnt_next = cnt + CW'(1);
          if (cnt == LAST) begin
            cnt_next = '0;
`ifdef PISO_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = IDLE;
            done_next  = 1'b1;
`endif
          end
        end
      end
`ifdef PISO_TX_PARITY_EN
      PARITY: begin
        sdata_o = par;
        if (sready_i) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  assign ready_o  = (state == IDLE);
  assign busy_o   = !ready_o;
  assign svalid_o = (state != IDLE);
  assign done_o   = done;

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
- REQ-001 SHALL have parameter N, default 5: parallel word width, N >= 1.
- REQ-002 SHALL have parameter IDLE_VAL, default 1'b1: level driven on sdata_o when no bit is offered.
- REQ-003 SHALL have parameter LSB_FIRST, default 1: 1 = bit 0 sent first, 0 = bit N-1 sent first.
- REQ-004 SHALL have port clk_i, input, 1: single clock, rising edge.
- REQ-005 SHALL have port rst_i, input, 1: reset, asynchronous, active-low.
- REQ-006 SHALL have port data_i, input, N: parallel word to send.
- REQ-007 SHALL have port valid_i, input, 1: data_i is valid.
- REQ-008 SHALL have port ready_o, output, 1: block accepts a word this cycle.
- REQ-009 SHALL have port sdata_o, output, 1: serial bit offered.
- REQ-010 SHALL have port svalid_o, output, 1: sdata_o is valid.
- REQ-011 SHALL have port sready_i, input, 1: sink accepts the offered bit.
- REQ-012 SHALL have port busy_o, output, 1: a word is in flight.
- REQ-013 SHALL have port done_o, output, 1: one-cycle pulse after the final bit is accepted.

Function
- REQ-014 SHALL implement states IDLE, SHIFT and PARITY; PARITY exists only with the macro defined (REQ-024).
- REQ-015 Word accept: the word SHALL be captured when valid_i && ready_o at a clock edge, and the block SHALL enter SHIFT on that same edge.
- REQ-016 ready_o SHALL be 1 only in IDLE; busy_o SHALL equal !ready_o.
- REQ-017 In SHIFT, svalid_o SHALL be 1 and sdata_o SHALL be the current bit, selected per LSB_FIRST; the first bit SHALL appear the cycle after accept (latency 1).
- REQ-018 Bit transfer: a bit SHALL be consumed when svalid_o && sready_i; the shift register SHALL advance and the bit counter (width $clog2(N+1)) SHALL increment.
- REQ-019 While sready_i = 0, sdata_o, svalid_o and the internal state SHALL hold unchanged, with no timeout.
- REQ-020 Final bit (counter = N-1 when accepted): the block SHALL go to IDLE, or to PARITY if enabled.
  - done_o SHALL pulse in the cycle after the last accepted bit (data, or parity if enabled).
  - ready_o SHALL be 1 in that same cycle.
- REQ-021 In IDLE, svalid_o SHALL be 0, sdata_o SHALL be IDLE_VAL, and sready_i SHALL be ignored.
- REQ-022 N = 1 SHALL complete after a single bit transfer.
- REQ-022a valid_i while busy SHALL be ignored; the source must hold its word until ready_o.

Reset
- REQ-023 rst_i = 0 SHALL, asynchronously and at any time including mid-word, force:
  - state to IDLE and the counter to 0;
  - ready_o = 1, busy_o = 0, svalid_o = 0, done_o = 0, sdata_o = IDLE_VAL.
  - A partially sent word SHALL be discarded, with no done_o pulse.

Configuration
- REQ-024 Macro PISO_TX_PARITY_EN SHALL control the parity feature.
  - Defined: after the last data bit, PARITY SHALL offer the even-parity bit (XOR of all N captured bits) with svalid_o = 1, using the same handshake; on acceptance the block SHALL go to IDLE.
  - Undefined: the PARITY state and its logic SHALL be absent, and the word SHALL be exactly N transfers.

Structure
- REQ-025 Package piso_tx_pkg SHALL hold the state enum typedef (IDLE, SHIFT, PARITY) and the constant for the IDLE reset encoding.
- REQ-026 Sub-module piso_shift_reg SHALL provide the N-bit load/shift register with asynchronous active-low clear, direction set by LSB_FIRST.
- REQ-026a piso_tx SHALL contain the FSM, counter, parity and handshake logic.

Verification
- REQ-027 N=5, LSB_FIRST=1, sready_i held 1, load 5'b10110 -> sdata_o 0,1,1,0,1 on 5 consecutive cycles starting 1 cycle after accept; done_o pulses after; ready_o back to 1.
- REQ-028 Same word, sready_i toggled 1,0,0,1,... -> each bit held stable while sready_i = 0; the same 5-bit order results; no bit dropped or duplicated.
- REQ-029 LSB_FIRST=0, load 5'b10011 -> sdata_o 1,0,0,1,1.
- REQ-030 PISO_TX_PARITY_EN defined, load 5'b10110 -> 5 data bits, then parity bit 1, then done_o; with 5'b10010 the parity bit is 0.
- REQ-031 Assert rst_i = 0 after the 2nd bit of 5'b11111 -> outputs at reset values immediately; after release, a new word 5'b00001 is sent complete and correct.
- REQ-032 valid_i held 1 with new data during SHIFT -> ignored; the in-flight word completes unchanged; the new word is accepted only at the first cycle with ready_o = 1.
